sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO. It is the same-domain successor of our dual-clock FIFO, for blocks whose producer and consumer share one clock. Beyond the existing full/empty/error behaviour it adds:
- configurable width and depth
- an occupancy count
- programmable almost-full and almost-empty thresholds
- a synchronous flush
- optional first-word-fall-through (FWFT) read mode

It sits between a producer and a consumer in the same clock domain and needs no pointer synchronisers.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
AFULL_TH, 12, almost_full asserts when count >= AFULL_TH (legal range 1..DEPTH)
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (legal range 0..DEPTH-1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of contents
w_enable  in  1  write request
w_data  in  DATA_W  write data
r_enable  in  1  read request
r_data  out  DATA_W  read data
r_valid  out  1  r_data holds a newly read word
w_full  out  1  FIFO holds DEPTH words
r_empty  out  1  FIFO holds 0 words
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  ADDR_W+1  current occupancy, 0..DEPTH
write_error  out  1  one-cycle pulse: write attempted while full
read_error  out  1  one-cycle pulse: read attempted while empty

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high (clk, rst).
- Reset values (rst high at a clock edge):
  - wptr = rptr = 0, count = 0
  - r_empty = 1, w_full = 0, almost_empty = 1, almost_full = 0
  - write_error = read_error = 0, r_valid = 0, r_data = 0
  - Storage array is not reset.
- rst has priority over flush; flush has priority over w_enable/r_enable.
- Flush:
  - Same end state as reset, except r_data holds its value.
  - No error pulses; any simultaneous write/read is discarded.
- All flags and count are registered or decoded from registered state only. There is no combinational path from w_enable/r_enable to any output.
- Write accept: w_enable && !w_full.
  - mem[wptr] <= w_data; wptr increments modulo DEPTH (natural ADDR_W wrap).
  - Write when full: data dropped, pointers unchanged, write_error = 1 for the next cycle.
- Read accept: r_enable && !r_empty.
  - rptr increments modulo DEPTH.
  - Read when empty: read_error = 1 for the next cycle, state unchanged.
- Count update: count_next = count + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
- Flag decode, valid on the same cycle count updates:
  - w_full = (count == DEPTH)
  - r_empty = (count == 0)
  - almost_full = (count >= AFULL_TH)
  - almost_empty = (count <= AEMPTY_TH)
- Boundary cases (full and empty are judged on the registered flags):
  - Full with both requests: read accepted, write rejected with write_error; count becomes DEPTH-1.
  - Empty with both requests: write accepted, read rejected with read_error; count becomes 1.
- Standard read mode (macro absent):
  - r_data <= mem[rptr] on an accepted read; r_valid = 1 in the following cycle only.
  - Otherwise r_data holds its value.
  - Latency: 1 cycle from the accepting edge.
- Pointer wrap: no special handling; full and empty are decided by count, so wptr == rptr is unambiguous.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined (FWFT mode):
  - r_data continuously presents mem[rptr] (head word); r_valid = !r_empty.
  - r_enable acts as a pop acknowledge.
  - A word written into an empty FIFO is visible on r_data in the cycle after its write edge.
  - r_data is don't-care while r_empty = 1.
- Not defined: standard registered read as described in Behaviour.

Test Plan:
1. Reset, then DATA_W=8 / ADDR_W=4; write 0x01..0x10 on 16 consecutive cycles -> count = 16, w_full = 1 after the 16th edge, almost_full = 1 from count 12; a 17th write (0xAA) -> write_error pulses 1 cycle, count stays 16.
2. From full, read 16 words -> r_data sequence 0x01..0x10, each with r_valid 1 cycle after its read; r_empty = 1 after the last; a 17th read -> read_error pulse, r_data holds 0x10.
3. Wrap: write 10, read 10, write 10, read 10 -> data order preserved across pointer wrap (rptr/wptr pass 15->0), count returns to 0.
4. Simultaneous events: at count 5, w_enable = r_enable = 1 for 4 cycles -> count stays 5, no errors; at full, both high -> count 15, write_error = 1; at empty, both high -> count 1, read_error = 1.
5. Write 7 words, then assert flush together with w_enable -> next cycle count = 0, r_empty = 1, almost_empty = 1, no write_error; a new write 0x55 then read -> 0x55. Repeat with rst high mid-burst -> all outputs at their reset values.
6. With SYNC_FIFO_FWFT_EN: write 0x3C into an empty FIFO -> the next cycle r_valid = 1 and r_data = 0x3C without r_enable; pulse r_enable -> r_valid = 0 and r_empty = 1.

Source files
------------

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bundle for sync_fifo_ctrl; the FIFO connects on the slave modport,
// the surrounding logic (producer + consumer) on the master modport.
interface sync_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              flush;
    logic              w_enable;
    logic [DATA_W-1:0] w_data;
    logic              r_enable;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              w_full;
    logic              r_empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              write_error;
    logic              read_error;

    modport master (
        output flush, w_enable, w_data, r_enable,
        input  r_data, r_valid, w_full, r_empty, almost_full, almost_empty,
               count, write_error, read_error
    );

    modport slave (
        input  flush, w_enable, w_data, r_enable,
        output r_data, r_valid, w_full, r_empty, almost_full, almost_empty,
               count, write_error, read_error
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_ctrl_if.slave bus
);
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C  = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              write_error_q, write_error_d;
    logic              read_error_q, read_error_d;
    logic              full, empty;
    logic              wr_acc, rd_acc;

    // Full/empty come from the registered count, so pointer equality never needs disambiguating.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wr_acc        = 1'b0;
        rd_acc        = 1'b0;
        write_error_d = 1'b0;
        read_error_d  = 1'b0;
        if (!bus.flush) begin
            wr_acc        = bus.w_enable && !full;
            rd_acc        = bus.r_enable && !empty;
            write_error_d = bus.w_enable && full;
            read_error_d  = bus.r_enable && empty;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PTR_ONE;
            if (rd_acc) rptr_d = rptr_q + PTR_ONE;
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            write_error_q <= 1'b0;
            read_error_q  <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            write_error_q <= write_error_d;
            read_error_q  <= read_error_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wptr_q] <= bus.w_data;
    end

    assign bus.count        = count_q;
    assign bus.w_full       = full;
    assign bus.r_empty      = empty;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.write_error  = write_error_q;
    assign bus.read_error   = read_error_q;

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always presented; r_enable only acknowledges the pop.
    assign bus.r_data  = mem_q[rptr_q];
    assign bus.r_valid = !empty;
`else
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;

    always_comb begin
        r_data_d  = r_data_q;
        r_valid_d = rd_acc;
        if (rd_acc) r_data_d = mem_q[rptr_q];
    end

    // Flush leaves r_data untouched; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign bus.r_data  = r_data_q;
    assign bus.r_valid = r_valid_q;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_sync_fifo_ctrl;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 12;
    localparam int AEMPTY_TH = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sync_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sync_fifo_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mq[$];
    bit         m_werr, m_rerr, m_valid;
    logic [7:0] m_rdata;

    typedef struct {
        bit         rst, flush, we;
        logic [7:0] wd;
        bit         re;
        int         cnt;
        bit         full, empty, aempty, werr, rerr, valid;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, flags derived from its size.
    task automatic model_edge(input bit r, input bit f, input bit we, input logic [7:0] wd, input bit re);
        bit was_full, was_empty;
        if (r) begin
            mq.delete();
            m_werr = 0; m_rerr = 0; m_valid = 0; m_rdata = 8'h00;
        end else if (f) begin
            mq.delete();
            m_werr = 0; m_rerr = 0; m_valid = 0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_werr  = we && was_full;
            m_rerr  = re && was_empty;
            m_valid = 0;
            if (re && !was_empty) begin
                m_rdata = mq.pop_front();
                m_valid = 1;
            end
            if (we && !was_full) mq.push_back(wd);
        end
    endtask

    task automatic drive_cycle(input bit r, input bit f, input bit we, input logic [7:0] wd, input bit re);
        rst          = r;
        bus.flush    = f;
        bus.w_enable = we;
        bus.w_data   = wd;
        bus.r_enable = re;
        @(posedge clk);
        model_edge(r, f, we, wd, re);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"},  32'(bus.count), 32'(mq.size()));
        check({tag, "_full"},   32'(bus.w_full), 32'(mq.size() == DEPTH));
        check({tag, "_empty"},  32'(bus.r_empty), 32'(mq.size() == 0));
        check({tag, "_afull"},  32'(bus.almost_full), 32'(mq.size() >= AFULL_TH));
        check({tag, "_aempty"}, 32'(bus.almost_empty), 32'(mq.size() <= AEMPTY_TH));
        check({tag, "_werr"},   32'(bus.write_error), 32'(m_werr));
        check({tag, "_rerr"},   32'(bus.read_error), 32'(m_rerr));
`ifdef SYNC_FIFO_FWFT_EN
        check({tag, "_valid"},  32'(bus.r_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check({tag, "_rdata"}, 32'(bus.r_data), 32'(mq[0]));
`else
        check({tag, "_valid"},  32'(bus.r_valid), 32'(m_valid));
        check({tag, "_rdata"},  32'(bus.r_data), 32'(m_rdata));
`endif
    endtask

    task automatic step(input string tag, input bit r, input bit f, input bit we,
                        input logic [7:0] wd, input bit re);
        drive_cycle(r, f, we, wd, re);
        check_model(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.flush = 1'b0; bus.w_enable = 1'b0; bus.w_data = '0; bus.r_enable = 1'b0;

        //           rst f  we wd     re  cnt full empty aempty werr rerr valid rdata
        vecs[0]  = '{1, 0, 0, 8'h00, 0,  0,  0,   1,    1,     0,   0,   0,    8'h00};
        vecs[1]  = '{0, 0, 1, 8'hA1, 0,  1,  0,   0,    1,     0,   0,   0,    8'h00};
        vecs[2]  = '{0, 0, 1, 8'hA2, 0,  2,  0,   0,    1,     0,   0,   0,    8'h00};
        vecs[3]  = '{0, 0, 1, 8'hA3, 1,  2,  0,   0,    1,     0,   0,   1,    8'hA1};
        vecs[4]  = '{0, 0, 0, 8'h00, 1,  1,  0,   0,    1,     0,   0,   1,    8'hA2};
        vecs[5]  = '{0, 0, 0, 8'h00, 1,  0,  0,   1,    1,     0,   0,   1,    8'hA3};
        vecs[6]  = '{0, 0, 0, 8'h00, 1,  0,  0,   1,    1,     0,   1,   0,    8'hA3};
        vecs[7]  = '{0, 0, 0, 8'h00, 0,  0,  0,   1,    1,     0,   0,   0,    8'hA3};
        vecs[8]  = '{0, 0, 1, 8'hB4, 1,  1,  0,   0,    1,     0,   1,   0,    8'hA3};
        vecs[9]  = '{0, 1, 1, 8'hC5, 0,  0,  0,   1,    1,     0,   0,   0,    8'hA3};
        vecs[10] = '{0, 0, 0, 8'h00, 1,  0,  0,   1,    1,     0,   1,   0,    8'hA3};
        vecs[11] = '{1, 0, 0, 8'h00, 0,  0,  0,   1,    1,     0,   0,   0,    8'h00};

        for (int i = 0; i < 12; i++) begin
            drive_cycle(vecs[i].rst, vecs[i].flush, vecs[i].we, vecs[i].wd, vecs[i].re);
            check($sformatf("vec%0d_count", i),  32'(bus.count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_full", i),   32'(bus.w_full), 32'(vecs[i].full));
            check($sformatf("vec%0d_empty", i),  32'(bus.r_empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d_aempty", i), 32'(bus.almost_empty), 32'(vecs[i].aempty));
            check($sformatf("vec%0d_werr", i),   32'(bus.write_error), 32'(vecs[i].werr));
            check($sformatf("vec%0d_rerr", i),   32'(bus.read_error), 32'(vecs[i].rerr));
`ifndef SYNC_FIFO_FWFT_EN
            check($sformatf("vec%0d_valid", i),  32'(bus.r_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_rdata", i),  32'(bus.r_data), 32'(vecs[i].rdata));
`endif
        end

        // Fill to full, then overflow.
        step("tp1_rst", 1, 0, 0, 8'h00, 0);
        for (int i = 1; i <= 16; i++) begin
            step("tp1_wr", 0, 0, 1, 8'(i), 0);
            check("tp1_afull", 32'(bus.almost_full), 32'(i >= 12));
        end
        check("tp1_count16", 32'(bus.count), 32'd16);
        check("tp1_full", 32'(bus.w_full), 32'd1);
        step("tp1_ovf", 0, 0, 1, 8'hAA, 0);
        check("tp1_ovf_werr", 32'(bus.write_error), 32'd1);
        check("tp1_ovf_count", 32'(bus.count), 32'd16);
        step("tp1_idle", 0, 0, 0, 8'h00, 0);
        check("tp1_werr_clear", 32'(bus.write_error), 32'd0);

        // Drain in order, then underflow.
        for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            check("tp2_head", 32'(bus.r_data), 32'(i));
`endif
            step("tp2_rd", 0, 0, 0, 8'h00, 1);
`ifndef SYNC_FIFO_FWFT_EN
            check("tp2_rdata", 32'(bus.r_data), 32'(i));
            check("tp2_valid", 32'(bus.r_valid), 32'd1);
`endif
        end
        check("tp2_empty", 32'(bus.r_empty), 32'd1);
        step("tp2_udf", 0, 0, 0, 8'h00, 1);
        check("tp2_rerr", 32'(bus.read_error), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check("tp2_rdata_hold", 32'(bus.r_data), 32'h10);
`endif

        // Pointer wrap: two rounds of 10 push past index 15.
        step("tp3_rst", 1, 0, 0, 8'h00, 0);
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < 10; i++) step("tp3_wr", 0, 0, 1, 8'($urandom), 0);
            for (int i = 0; i < 10; i++) step("tp3_rd", 0, 0, 0, 8'h00, 1);
        end
        check("tp3_count0", 32'(bus.count), 32'd0);

        // Simultaneous read/write at mid, full and empty.
        step("tp4_rst", 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step("tp4_fill", 0, 0, 1, 8'($urandom), 0);
        for (int i = 0; i < 4; i++) step("tp4_both", 0, 0, 1, 8'($urandom), 1);
        check("tp4_count5", 32'(bus.count), 32'd5);
        for (int i = 0; i < 11; i++) step("tp4_fill", 0, 0, 1, 8'($urandom), 0);
        step("tp4_both_full", 0, 0, 1, 8'h77, 1);
        check("tp4_full_count", 32'(bus.count), 32'd15);
        check("tp4_full_werr", 32'(bus.write_error), 32'd1);
        for (int i = 0; i < 15; i++) step("tp4_drain", 0, 0, 0, 8'h00, 1);
        step("tp4_both_empty", 0, 0, 1, 8'h66, 1);
        check("tp4_empty_count", 32'(bus.count), 32'd1);
        check("tp4_empty_rerr", 32'(bus.read_error), 32'd1);

        // Flush beats a concurrent write; reset mid-burst.
        step("tp5_rst", 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) step("tp5_wr", 0, 0, 1, 8'($urandom), 0);
        step("tp5_flush", 0, 1, 1, 8'h99, 0);
        check("tp5_fl_count", 32'(bus.count), 32'd0);
        check("tp5_fl_empty", 32'(bus.r_empty), 32'd1);
        check("tp5_fl_aempty", 32'(bus.almost_empty), 32'd1);
        check("tp5_fl_werr", 32'(bus.write_error), 32'd0);
        step("tp5_wr55", 0, 0, 1, 8'h55, 0);
`ifdef SYNC_FIFO_FWFT_EN
        check("tp5_head55", 32'(bus.r_data), 32'h55);
`endif
        step("tp5_rd55", 0, 0, 0, 8'h00, 1);
`ifndef SYNC_FIFO_FWFT_EN
        check("tp5_rdata55", 32'(bus.r_data), 32'h55);
`endif
        for (int i = 0; i < 3; i++) step("tp5_burst", 0, 0, 1, 8'($urandom), 0);
        step("tp5_rst_mid", 1, 0, 1, 8'h44, 0);
        check("tp5_rst_count", 32'(bus.count), 32'd0);
        check("tp5_rst_empty", 32'(bus.r_empty), 32'd1);
        check("tp5_rst_full", 32'(bus.w_full), 32'd0);
        check("tp5_rst_afull", 32'(bus.almost_full), 32'd0);
        check("tp5_rst_valid", 32'(bus.r_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("tp5_rst_rdata", 32'(bus.r_data), 32'd0);
`endif

`ifdef SYNC_FIFO_FWFT_EN
        step("tp6_wr3c", 0, 0, 1, 8'h3C, 0);
        check("tp6_valid", 32'(bus.r_valid), 32'd1);
        check("tp6_rdata", 32'(bus.r_data), 32'h3C);
        step("tp6_pop", 0, 0, 0, 8'h00, 1);
        check("tp6_valid0", 32'(bus.r_valid), 32'd0);
        check("tp6_empty", 32'(bus.r_empty), 32'd1);
`endif

        // Randomized traffic with a write bias that drifts so both full and empty are visited.
        for (int i = 0; i < 3000; i++) begin
            bit r, f, we, re;
            int wbias;
            wbias = ((i / 200) % 2 == 0) ? 70 : 30;
            r  = ($urandom_range(0, 299) == 0);
            f  = ($urandom_range(0, 99) == 0);
            we = ($urandom_range(0, 99) < wbias);
            re = ($urandom_range(0, 99) < 100 - wbias);
            step("rnd", r, f, we, 8'($urandom), re);
        end

        drive_cycle(0, 0, 0, 8'h00, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
